sum_tx_sequencer: RTL

SUM_TX_SEQUENCER -- requirements
Module: sum_tx_sequencer

---
 rtl/sum_tx_sequencer_pkg.sv | 19 +
 rtl/sum_tx_sequencer_word_serializer.sv | 38 +++
 rtl/sum_tx_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sum_tx_sequencer_pkg.sv
// Shared constants and FSM encoding for the sum-block UART transmit sequencer.
// Defaults describe a 768-word block of 40-bit sums sent as 5 bytes each.
package sum_tx_sequencer_pkg;

  localparam int SUM_ADDR_W      = 10;
  localparam int SUM_DATA_W      = 40;
  localparam int SUM_BYTES       = 5;
  localparam int SUM_BLOCK_WORDS = 768;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_LATCH  = 3'd2,
    ST_SEND   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FINISH = 3'd5
  } sum_tx_state_e;

endpackage

// File: rtl/sum_tx_sequencer_word_serializer.sv
// Holds one sum word and hands it out a byte at a time, most significant byte first.
// The byte counter tells the sequencer when the last byte of the word has gone out.
module word_serializer #(
  parameter int DATA_W = 40,
  parameter int NBYTES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              shift,
  output logic [7:0]        byte_out,
  output logic              last
);

  localparam int CNT_W = $clog2(NBYTES + 1);

  logic [DATA_W-1:0] shreg_reg;
  logic [CNT_W-1:0]  cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else if (load) begin
      shreg_reg <= din;
      cnt_reg   <= '0;
    end else if (shift) begin
      shreg_reg <= {shreg_reg[DATA_W-9:0], 8'h00};
      cnt_reg   <= cnt_reg + CNT_W'(1);
    end
  end

  assign byte_out = shreg_reg[DATA_W-1 -: 8];
  assign last     = (cnt_reg == CNT_W'(NBYTES - 1));

endmodule

// File: rtl/sum_tx_sequencer.sv
// Reads num_words sums from the sum RAM and streams each one to a UART, MSB byte first,
// handshaking on tx_rdy: fire a byte when ready, then wait for the UART to drop ready.
module sum_tx_sequencer
  import sum_tx_sequencer_pkg::*;
#(
  parameter int ADDR_W = SUM_ADDR_W,
  parameter int DATA_W = SUM_DATA_W,
  parameter int NBYTES = SUM_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  output logic [ADDR_W-1:0] sum_read_addr,
  output logic              sum_read_en,
  input  logic [DATA_W-1:0] sum_data,
  input  logic              tx_rdy,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done
);

  sum_tx_state_e     state_reg, state_next;
  logic [ADDR_W-1:0] word_cnt_reg, word_cnt_next;
  logic [ADDR_W:0]   num_words_reg, num_words_next;
  logic [ADDR_W:0]   word_cnt_inc;
  logic              sum_read_en_reg, tx_en_reg, busy_reg, done_reg;
  logic [7:0]        tx_data_reg;
  logic              ser_clr, ser_load, ser_shift, ser_last;
  logic [7:0]        ser_byte;
  logic              send_fire;

  assign word_cnt_inc = {1'b0, word_cnt_reg} + {{ADDR_W{1'b0}}, 1'b1};
  assign send_fire    = (state_reg == ST_SEND) && tx_rdy;

  word_serializer #(
    .DATA_W (DATA_W),
    .NBYTES (NBYTES)
  ) u_word_serializer (
    .clk      (clk),
    .reset    (reset),
    .clr      (ser_clr),
    .load     (ser_load),
    .din      (sum_data),
    .shift    (ser_shift),
    .byte_out (ser_byte),
    .last     (ser_last)
  );

  always_comb begin
    state_next     = state_reg;
    word_cnt_next  = word_cnt_reg;
    num_words_next = num_words_reg;
    ser_clr        = 1'b0;
    ser_load       = 1'b0;
    ser_shift      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          num_words_next = num_words;
          word_cnt_next  = '0;
          ser_clr        = 1'b1;
          state_next     = (num_words == '0) ? ST_FINISH : ST_READ;
        end
      end
      ST_READ:  state_next = ST_LATCH;
      ST_LATCH: begin
        ser_load   = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (tx_rdy) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The UART dropping tx_rdy is the only proof the byte was taken.
        if (!tx_rdy) begin
          ser_shift = 1'b1;
          if (!ser_last) begin
            state_next = ST_SEND;
          end else if (word_cnt_inc == num_words_reg) begin
            state_next = ST_FINISH;
          end else begin
            word_cnt_next = word_cnt_inc[ADDR_W-1:0];
            state_next    = ST_READ;
          end
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      word_cnt_reg    <= '0;
      num_words_reg   <= '0;
      sum_read_en_reg <= 1'b0;
      tx_en_reg       <= 1'b0;
      tx_data_reg     <= 8'h00;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      word_cnt_reg    <= word_cnt_next;
      num_words_reg   <= num_words_next;
      // Outputs are registered from the next state so they line up with the state they belong to.
      sum_read_en_reg <= (state_next == ST_READ);
      tx_en_reg       <= send_fire;
      if (send_fire) tx_data_reg <= ser_byte;
      busy_reg        <= (state_next != ST_IDLE) && (state_next != ST_FINISH);
      done_reg        <= (state_next == ST_FINISH);
    end
  end

  assign sum_read_addr = word_cnt_reg;
  assign sum_read_en   = sum_read_en_reg;
  assign tx_en         = tx_en_reg;
  assign tx_data       = tx_data_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule
